seq_mag_comparator: RTL
=======================

SEQ_MAG_COMPARATOR -- requirements
Module: seq_mag_comparator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the operand width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, meaning the bits compared per cycle.
REQ-003 The block SHALL derive NSLICE = WIDTH/CHUNK.
REQ-004 Elaboration SHALL fail if WIDTH % CHUNK != 0 or CHUNK < 1.
REQ-005 Port clk, input, 1 bit: single clock, rising-edge.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port start, input, 1 bit: request a compare, sampled on the clk edge.
REQ-008 Port a, input, WIDTH bits: operand A, captured when start is accepted.
REQ-009 Port b, input, WIDTH bits: operand B, captured when start is accepted.
REQ-010 Port signed_mode, input, 1 bit: 1 = two's-complement compare, 0 = unsigned; captured with the operands.
REQ-011 Port busy, output, 1 bit: compare in progress.
REQ-012 Port done, output, 1 bit: one-cycle pulse when the result becomes valid.
REQ-013 Ports eq, gt, lt, outputs, 1 bit each: result flags for A==B, A>B and A<B.
REQ-014 Port slices, output, $clog2(NSLICE)+1 bits: number of slices examined for the last result.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, CMP and DONE.
REQ-016 start SHALL be accepted when busy=0 (IDLE or DONE).
- On acceptance: capture a, b and signed_mode; clear the slice index; go to CMP.
REQ-017 start while busy=1 SHALL be ignored; the captured operands SHALL NOT change.
REQ-018 In CMP, each cycle SHALL compare one CHUNK slice, MSB slice first, and increment slices.
REQ-019 In signed mode, the sign bit of both operands SHALL be inverted in slice 0 only before comparing.
REQ-020 The first unequal slice SHALL end the compare early and set gt or lt from that slice, then go to DONE.
REQ-021 If all NSLICE slices are equal, the block SHALL set eq=1 and go to DONE after the last slice.
REQ-022 Latency: with k slices examined, done SHALL be high in the k-th cycle after the start edge (1 <= k <= NSLICE).
REQ-023 DONE SHALL last exactly one cycle and then go to IDLE, unless start is accepted in that cycle, in which case it goes to CMP.
REQ-024 busy SHALL be 1 only in CMP.
REQ-025 eq, gt, lt and slices SHALL be registered; exactly one flag SHALL be high after the first done.
REQ-026 Result outputs SHALL hold until the next done.
REQ-027 Result outputs SHALL NOT change while CMP is in progress.

Reset
REQ-028 When rst_n is low, the state SHALL be IDLE, and busy, done, eq, gt, lt and slices SHALL all be 0, at any time including mid-compare.
REQ-029 Reset SHALL take effect immediately (asynchronously).
REQ-030 Release of reset SHALL be followed by normal operation from the next clk edge.
REQ-031 A start sampled on the first edge after reset release SHALL be accepted.

Structure
REQ-032 A shared package cmp_pkg SHALL hold:
- the state enum (IDLE/CMP/DONE);
- a result struct {eq, gt, lt}.
REQ-033 One combinational sub-module, slice_cmp, SHALL be instantiated once.
- Parameter: CHUNK.
- Inputs: two CHUNK-bit slices.
- Outputs: s_eq and s_gt.
REQ-034 The slice multiplexing and the sign-bit inversion SHALL live in the top module.

Verification (WIDTH=16, CHUNK=4)
REQ-035 Scenario: a=b=16'h1234, unsigned -> eq=1, gt=0, lt=0, slices=4, done pulses 4 cycles after start, busy high 4 cycles.
REQ-036 Scenario: a=16'hA000, b=16'h1FFF, unsigned -> gt=1, slices=1, done 1 cycle after start.
REQ-037 Scenario: a=16'h8000, b=16'h0001:
- signed_mode=1 -> lt=1, slices=1;
- signed_mode=0 -> gt=1.
REQ-038 Scenario: a=16'h12F0, b=16'h12F1 -> lt=1, slices=4.
- A second start with different operands during busy is ignored, and the result still matches the first operands.
REQ-039 Scenario: start asserted in the DONE cycle with a=b=16'h0000 -> new compare begins with no idle cycle, eq=1 after 4 more cycles.
REQ-040 Scenario: rst_n pulsed low after slice 2 of an equal compare -> all outputs 0 immediately; no done follows; the next start completes normally.

Source files
------------

// File: rtl/seq_mag_comparator_pkg.sv
// Shared types for the sequential magnitude comparator: FSM state encoding
// and the registered result flags.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } result_t;

endpackage

// File: rtl/seq_mag_comparator_slice_cmp.sv
// Combinational unsigned compare of one CHUNK-bit slice pair.
module slice_cmp #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_slice,
  input  logic [CHUNK-1:0] b_slice,
  output logic             s_eq,
  output logic             s_gt
);

  // Slice equality and unsigned greater-than.
  always_comb begin
    s_eq = (a_slice == b_slice);
    s_gt = (a_slice > b_slice);
  end

endmodule

// File: rtl/seq_mag_comparator.sv
// Sequential magnitude comparator: walks the operands one CHUNK slice per
// cycle from the MSB end and stops at the first differing slice.
module seq_mag_comparator
  import cmp_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int CHUNK  = 4,
  localparam int NSLICE = WIDTH / CHUNK,
  localparam int SW     = $clog2(NSLICE) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic [SW-1:0]    slices
);

  localparam logic [SW-1:0] LAST = SW'(NSLICE - 1);

  if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_param
    $error("seq_mag_comparator: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state_q;
  logic [SW-1:0]    idx_q;
  logic [SW-1:0]    slices_q;
  logic             done_q;
  result_t          res_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sgn_q;

  logic             accept;
  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic             s_eq;
  logic             s_gt;

  assign accept = start && (state_q != CMP);

  // Pick the slice under examination (MSB slice first); in signed mode the
  // sign bits of the top slice are flipped so an unsigned slice compare
  // orders two's-complement values correctly.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_q == SW'(i)) begin
        a_sl = a_q[WIDTH-1-i*CHUNK -: CHUNK];
        b_sl = b_q[WIDTH-1-i*CHUNK -: CHUNK];
      end
    end
    if (sgn_q && (idx_q == '0)) begin
      a_sl[CHUNK-1] = ~a_sl[CHUNK-1];
      b_sl[CHUNK-1] = ~b_sl[CHUNK-1];
    end
  end

  slice_cmp #(
    .CHUNK(CHUNK)
  ) u_slice_cmp (
    .a_slice(a_sl),
    .b_slice(b_sl),
    .s_eq   (s_eq),
    .s_gt   (s_gt)
  );

  // Operand capture on an accepted start; held untouched while comparing.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q   <= a;
      b_q   <= b;
      sgn_q <= signed_mode;
    end
  end

  // Control FSM: IDLE -> CMP (one slice per cycle) -> DONE (one cycle).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      slices_q <= '0;
      done_q   <= 1'b0;
      res_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            idx_q   <= '0;
            state_q <= CMP;
          end
        end
        CMP: begin
          if (!s_eq) begin
            res_q    <= result_t'{eq: 1'b0, gt: s_gt, lt: ~s_gt};
            slices_q <= idx_q + SW'(1);
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else if (idx_q == LAST) begin
            res_q    <= result_t'{eq: 1'b1, gt: 1'b0, lt: 1'b0};
            slices_q <= idx_q + SW'(1);
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            idx_q <= idx_q + SW'(1);
          end
        end
        DONE: begin
          if (start) begin
            idx_q   <= '0;
            state_q <= CMP;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = (state_q == CMP);
  assign done   = done_q;
  assign eq     = res_q.eq;
  assign gt     = res_q.gt;
  assign lt     = res_q.lt;
  assign slices = slices_q;

endmodule
